// File: rtl/pwm_compare_stage.sv
// PWM compare stage fed by a wrap-around timer: duty updates go through a shadow
// register and become active only at the period boundary, so the output never glitches.
module pwm_compare_stage #(
   parameter int FINAL_VALUE = 255,
   localparam int BITS = $clog2(FINAL_VALUE),
   localparam int DW = BITS + 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          enable,
   input  logic [BITS-1:0] count,
   input  logic [DW-1:0] duty_in,
   input  logic          duty_valid,
   output logic          duty_ready,
   output logic          pwm_out,
   output logic          period_done,
   output logic          duty_applied,
   output logic [DW-1:0] duty_active
);

   localparam logic [DW-1:0]   FULL_DUTY  = DW'(FINAL_VALUE + 1);
   localparam logic [BITS-1:0] LAST_COUNT = BITS'(FINAL_VALUE);
   localparam logic [0:0]      ST_IDLE    = 1'b0;
   localparam logic [0:0]      ST_PENDING = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [DW-1:0] shadow_q, shadow_d;
   logic [DW-1:0] duty_active_q, duty_active_d;
   logic          duty_ready_q, duty_ready_d;
   logic          pwm_q, pwm_d;
   logic          period_done_q, period_done_d;
   logic          duty_applied_q, duty_applied_d;
   logic          boundary_s;
   logic          accept_s;

   // Requests above a full period would never change the compare result, so clamp them.
   function automatic logic [DW-1:0] sat_duty(input logic [DW-1:0] d);
      if (d > FULL_DUTY) begin
         sat_duty = FULL_DUTY;
      end else begin
         sat_duty = d;
      end
   endfunction

   // Next-state logic: handshake FSM, apply at boundary, compare against active duty.
   always_comb begin
      state_d        = state_q;
      shadow_d       = shadow_q;
      duty_active_d  = duty_active_q;
      duty_applied_d = 1'b0;
      boundary_s     = enable && (count == LAST_COUNT);
      accept_s       = duty_valid && (state_q == ST_IDLE);
      case (state_q)
         ST_IDLE: begin
            // An accept coinciding with a boundary waits for the next one.
            if (accept_s) begin
               state_d  = ST_PENDING;
               shadow_d = sat_duty(duty_in);
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_PENDING: begin
            if (boundary_s) begin
               state_d        = ST_IDLE;
               duty_active_d  = shadow_q;
               duty_applied_d = 1'b1;
            end else begin
               state_d        = ST_PENDING;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      duty_ready_d  = (state_d == ST_IDLE);
      pwm_d         = ({1'b0, count} < duty_active_q);
      period_done_d = boundary_s;
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q        <= ST_IDLE;
         shadow_q       <= {DW{1'b0}};
         duty_active_q  <= {DW{1'b0}};
         duty_ready_q   <= 1'b1;
         pwm_q          <= 1'b0;
         period_done_q  <= 1'b0;
         duty_applied_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         shadow_q       <= shadow_d;
         duty_active_q  <= duty_active_d;
         duty_ready_q   <= duty_ready_d;
         pwm_q          <= pwm_d;
         period_done_q  <= period_done_d;
         duty_applied_q <= duty_applied_d;
      end
   end

   assign duty_ready   = duty_ready_q;
   assign pwm_out      = pwm_q;
   assign period_done  = period_done_q;
   assign duty_applied = duty_applied_q;
   assign duty_active  = duty_active_q;

endmodule

// File: tb/tb_pwm_compare_stage.sv
// Directed bench for pwm_compare_stage with a 10-count timer model upstream.
module tb_pwm_compare_stage;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       enable;
   logic [3:0] cnt;
   logic [4:0] duty_in;
   logic       duty_valid;
   logic       duty_ready;
   logic       pwm_out;
   logic       period_done;
   logic       duty_applied;
   logic [4:0] duty_active;

   int n_checks = 0;
   int n_errors = 0;

   pwm_compare_stage #(.FINAL_VALUE(9)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .count(cnt),
      .duty_in(duty_in), .duty_valid(duty_valid), .duty_ready(duty_ready),
      .pwm_out(pwm_out), .period_done(period_done), .duty_applied(duty_applied),
      .duty_active(duty_active)
   );

   always #5 clk = ~clk;

   // Upstream wrap-around timer, FINAL_VALUE = 9
   always @(posedge clk) begin
      if (!reset_n) cnt <= 4'd0;
      else if (enable) cnt <= (cnt == 4'd9) ? 4'd0 : cnt + 4'd1;
   end

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_count(input int v);
      for (int i = 0; i < 30; i++) begin
         if (cnt == 4'(v)) break;
         tick();
      end
      check_eq("wait_count", int'(cnt), v);
   endtask

   task automatic wait_applied(input string tag, output int ticks, output int highs);
      ticks = 0;
      highs = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         ticks++;
         highs += int'(pwm_out);
         if (duty_applied) break;
      end
      check_eq({tag, "_applied"}, int'(duty_applied), 1);
   endtask

   task automatic measure_period(output int highs, output int pds, output logic [9:0] pat);
      highs = 0;
      pds   = 0;
      pat   = 10'd0;
      for (int i = 0; i < 10; i++) begin
         tick();
         pat[i] = pwm_out;
         highs += int'(pwm_out);
         pds   += int'(period_done);
      end
   endtask

   task automatic apply_duty(input string tag, input logic [4:0] v);
      int t, h;
      duty_valid = 1'b1;
      duty_in    = v;
      tick();
      duty_valid = 1'b0;
      wait_applied(tag, t, h);
   endtask

   initial begin
      int t, h, pd, pulses;
      logic [9:0] pat;
      reset_n    = 1'b0;
      enable     = 1'b1;
      duty_valid = 1'b0;
      duty_in    = 5'd0;
      tick();
      tick();
      check_eq("rst_pwm", int'(pwm_out), 0);
      check_eq("rst_pd", int'(period_done), 0);
      check_eq("rst_applied", int'(duty_applied), 0);
      check_eq("rst_ready", int'(duty_ready), 1);
      check_eq("rst_active", int'(duty_active), 0);
      reset_n = 1'b1;

      // Basic duty 3 accepted at count 2
      wait_count(2);
      duty_valid = 1'b1;
      duty_in    = 5'd3;
      tick();
      duty_valid = 1'b0;
      check_eq("basic_ready_low", int'(duty_ready), 0);
      wait_applied("basic", t, h);
      check_eq("basic_latency", t, 7);
      check_eq("basic_cnt_at_apply", int'(cnt), 0);
      check_eq("basic_pd_with_apply", int'(period_done), 1);
      check_eq("basic_active", int'(duty_active), 3);
      check_eq("basic_ready_back", int'(duty_ready), 1);
      measure_period(h, pd, pat);
      check_eq("basic_pattern", int'(pat), 10'b0000000111);
      check_eq("basic_period_done", pd, 1);
      measure_period(h, pd, pat);
      check_eq("basic_highs2", h, 3);
      check_eq("basic_period_done2", pd, 1);

      // Extremes and saturation
      apply_duty("zero", 5'd0);
      measure_period(h, pd, pat);
      check_eq("zero_highs", h, 0);
      apply_duty("full", 5'd10);
      measure_period(h, pd, pat);
      check_eq("full_highs", h, 10);
      apply_duty("sat", 5'd15);
      check_eq("sat_active", int'(duty_active), 10);
      measure_period(h, pd, pat);
      check_eq("sat_highs", h, 10);

      // Handshake: 7 offered while 5 is pending
      duty_valid = 1'b1;
      duty_in    = 5'd5;
      tick();
      duty_in    = 5'd7;
      tick();
      tick();
      check_eq("hs_ready_low", int'(duty_ready), 0);
      check_eq("hs_active_old", int'(duty_active), 10);
      wait_applied("hs5", t, h);
      check_eq("hs5_active", int'(duty_active), 5);
      check_eq("hs5_ready", int'(duty_ready), 1);
      tick();
      duty_valid = 1'b0;
      check_eq("hs7_ready_low", int'(duty_ready), 0);
      check_eq("hs5_first_pwm", int'(pwm_out), 1);
      wait_applied("hs7", t, h);
      check_eq("hs5_highs_rest", h, 4);
      check_eq("hs7_active", int'(duty_active), 7);
      measure_period(h, pd, pat);
      check_eq("hs7_highs", h, 7);

      // Accept coinciding with the boundary
      wait_count(9);
      duty_valid = 1'b1;
      duty_in    = 5'd6;
      tick();
      duty_valid = 1'b0;
      check_eq("sim_no_apply", int'(duty_applied), 0);
      check_eq("sim_pd", int'(period_done), 1);
      check_eq("sim_active_kept", int'(duty_active), 7);
      check_eq("sim_ready_low", int'(duty_ready), 0);
      wait_applied("sim", t, h);
      check_eq("sim_latency", t, 10);
      check_eq("sim_old_highs", h, 7);
      check_eq("sim_active", int'(duty_active), 6);

      // Enable stall with 5 pending
      duty_valid = 1'b1;
      duty_in    = 5'd5;
      tick();
      duty_valid = 1'b0;
      wait_count(4);
      enable = 1'b0;
      pulses = 0;
      h      = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         pulses += int'(period_done) + int'(duty_applied);
         h      += int'(pwm_out);
      end
      check_eq("stall_pulses", pulses, 0);
      check_eq("stall_pwm_high", h, 20);
      check_eq("stall_ready_low", int'(duty_ready), 0);
      enable = 1'b1;
      wait_applied("stall", t, h);
      check_eq("stall_latency", t, 6);
      check_eq("stall_active", int'(duty_active), 5);

      // Reset while pending at count 6
      duty_valid = 1'b1;
      duty_in    = 5'd8;
      tick();
      duty_valid = 1'b0;
      wait_count(6);
      reset_n = 1'b0;
      tick();
      check_eq("mrst_pwm", int'(pwm_out), 0);
      check_eq("mrst_pd", int'(period_done), 0);
      check_eq("mrst_applied", int'(duty_applied), 0);
      check_eq("mrst_ready", int'(duty_ready), 1);
      check_eq("mrst_active", int'(duty_active), 0);
      reset_n = 1'b1;
      pulses = 0;
      h      = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         pulses += int'(duty_applied);
         h      += int'(pwm_out);
      end
      check_eq("mrst_never_applied", pulses, 0);
      check_eq("mrst_pwm_low", h, 0);
      check_eq("mrst_active_after", int'(duty_active), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
